// File: rtl/tim1_ctrl.sv
// rtl/tim1_ctrl.sv - TIMER1 configuration sequencer, duty-cycle updater and flag acknowledger
module tim1_ctrl #(
    parameter int unsigned PSC_VAL  = 2,
    parameter int unsigned ARR_VAL  = 9999,
    parameter int unsigned CCR1_VAL = 2500,
    parameter int unsigned RST_HOLD = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic        i_duty_wr,
    input  logic [31:0] i_duty_val,
    input  logic        i_uif_in,
    input  logic        i_cc1if_in,
    output logic        o_tim_rst,
    output logic [3:0]  o_ld_reg,
    output logic [31:0] o_ld_data,
    output logic        o_uif_rst,
    output logic        o_cc1if_rst,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_upd_cnt
);

    localparam logic [3:0] REG_CR1   = 4'd0;
    localparam logic [3:0] REG_DIER  = 4'd1;
    localparam logic [3:0] REG_EGR   = 4'd3;
    localparam logic [3:0] REG_CNT   = 4'd4;
    localparam logic [3:0] REG_PSC   = 4'd5;
    localparam logic [3:0] REG_ARR   = 4'd6;
    localparam logic [3:0] REG_CCMR1 = 4'd7;
    localparam logic [3:0] REG_CCER  = 4'd8;
    localparam logic [3:0] REG_CCR1  = 4'd9;
    localparam logic [3:0] REG_NONE  = 4'hA;

    localparam logic [31:0] ARR_LIM   = 32'(ARR_VAL);
    localparam logic [15:0] HOLD_LOAD = 16'(RST_HOLD - 1);
    localparam logic [3:0]  LAST_STEP = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_CFG,
        S_RUN,
        S_UPD,
        S_STOP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_step;
    logic [3:0]  w_step_nxt;
    logic [15:0] r_hold_cnt;
    logic [15:0] w_hold_nxt;

    logic        r_tim_rst;
    logic [3:0]  r_ld_reg;
    logic [31:0] r_ld_data;
    logic        r_busy;
    logic        r_done;
    logic        r_uif_rst;
    logic        r_cc1if_rst;
    logic [15:0] r_upd_cnt;
    logic        r_uif_prev;
    logic        r_cc1if_prev;

    logic        w_tim_rst;
    logic [3:0]  w_ld_reg;
    logic [31:0] w_ld_data;
    logic        w_busy;
    logic        w_done;
    logic        w_svc_state;
    logic        w_uif_svc;
    logic        w_cc1if_svc;
    logic [35:0] w_cfg_wr;
    logic [31:0] w_duty_clamped;

    // Fixed bring-up sequence: counter cleared and timer disabled before PSC/ARR, CEN set last.
    function automatic logic [35:0] cfg_write(input logic [3:0] step);
        case (step)
            4'd0:    cfg_write = {REG_CNT,   32'd0};
            4'd1:    cfg_write = {REG_CR1,   32'h0000_00A0};
            4'd2:    cfg_write = {REG_PSC,   32'(PSC_VAL)};
            4'd3:    cfg_write = {REG_ARR,   ARR_LIM};
            4'd4:    cfg_write = {REG_DIER,  32'd0};
            4'd5:    cfg_write = {REG_EGR,   32'h0000_0003};
            4'd6:    cfg_write = {REG_CCMR1, 32'h0000_0001};
            4'd7:    cfg_write = {REG_CCR1,  32'(CCR1_VAL)};
            4'd8:    cfg_write = {REG_CCER,  32'h0000_0005};
            4'd9:    cfg_write = {REG_CR1,   32'h0000_00A1};
            default: cfg_write = {REG_NONE,  32'd0};
        endcase
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_step     <= 4'd0;
            r_hold_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_step     <= w_step_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_hold_nxt  = r_hold_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_HOLD;
                    w_hold_nxt  = HOLD_LOAD;
                end
            end
            S_HOLD: begin
                if (i_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (r_hold_cnt == 16'd0) begin
                    w_state_nxt = S_CFG;
                    w_step_nxt  = 4'd0;
                end else begin
                    w_hold_nxt = r_hold_cnt - 16'd1;
                end
            end
            S_CFG: begin
                if (i_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (r_step == LAST_STEP) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_step_nxt = r_step + 4'd1;
                end
            end
            S_RUN: begin
                // stop outranks a simultaneous duty request, which is then dropped
                if (i_stop) begin
                    w_state_nxt = S_STOP;
                end else if (i_duty_wr) begin
                    w_state_nxt = S_UPD;
                end
            end
            S_UPD:   w_state_nxt = S_RUN;
            S_STOP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_cfg_wr       = cfg_write(w_step_nxt);
    assign w_duty_clamped = (i_duty_val > ARR_LIM) ? ARR_LIM : i_duty_val;

    // Outputs are decoded from the next state so the registered value lines up with that state.
    always_comb begin
        w_tim_rst = 1'b1;
        w_ld_reg  = REG_NONE;
        w_ld_data = 32'd0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        case (w_state_nxt)
            S_HOLD: begin
                w_busy = 1'b1;
            end
            S_CFG: begin
                w_tim_rst = 1'b0;
                w_busy    = 1'b1;
                w_ld_reg  = w_cfg_wr[35:32];
                w_ld_data = w_cfg_wr[31:0];
            end
            S_RUN: begin
                w_tim_rst = 1'b0;
                w_done    = 1'b1;
            end
            S_UPD: begin
                w_tim_rst = 1'b0;
                w_busy    = 1'b1;
                w_ld_reg  = REG_CCR1;
                w_ld_data = w_duty_clamped;
            end
            S_STOP: begin
                w_tim_rst = 1'b0;
                w_busy    = 1'b1;
                w_ld_reg  = REG_CR1;
                w_ld_data = 32'h0000_00A0;
            end
            default: begin
                w_tim_rst = 1'b1;
            end
        endcase
    end

    assign w_svc_state = (r_state == S_RUN) || (r_state == S_UPD);
    assign w_uif_svc   = w_svc_state && i_uif_in && !r_uif_prev;
    assign w_cc1if_svc = w_svc_state && i_cc1if_in && !r_cc1if_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tim_rst    <= 1'b1;
            r_ld_reg     <= REG_NONE;
            r_ld_data    <= 32'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_uif_rst    <= 1'b0;
            r_cc1if_rst  <= 1'b0;
            r_upd_cnt    <= 16'd0;
            r_uif_prev   <= 1'b0;
            r_cc1if_prev <= 1'b0;
        end else begin
            r_tim_rst    <= w_tim_rst;
            r_ld_reg     <= w_ld_reg;
            r_ld_data    <= w_ld_data;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_uif_rst    <= w_uif_svc;
            r_cc1if_rst  <= w_cc1if_svc;
            r_uif_prev   <= i_uif_in;
            r_cc1if_prev <= i_cc1if_in;
            if (w_uif_svc) begin
                r_upd_cnt <= r_upd_cnt + 16'd1;
            end
        end
    end

    assign o_tim_rst   = r_tim_rst;
    assign o_ld_reg    = r_ld_reg;
    assign o_ld_data   = r_ld_data;
    assign o_uif_rst   = r_uif_rst;
    assign o_cc1if_rst = r_cc1if_rst;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_upd_cnt   = r_upd_cnt;

endmodule

// File: tb/tb_tim1_ctrl.sv
// tb/tb_tim1_ctrl.sv - randomized self-checking bench for tim1_ctrl against a spec-level model
module tb_tim1_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        duty_wr = 1'b0;
    logic [31:0] duty_val = 32'd0;
    logic        uif_in = 1'b0;
    logic        cc1if_in = 1'b0;
    logic        tim_rst;
    logic [3:0]  ld_reg;
    logic [31:0] ld_data;
    logic        uif_rst;
    logic        cc1if_rst;
    logic        busy;
    logic        done;
    logic [15:0] upd_cnt;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [15:0] exp_upd = 16'd0;

    int cfg_r[10] = '{4, 0, 5, 6, 1, 3, 7, 9, 8, 0};
    int cfg_d[10] = '{0, 'hA0, 2, 9999, 0, 3, 1, 2500, 5, 'hA1};

    logic [3:0]  wq_reg[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];
    int          uq[$];
    int          cq[$];

    tim1_ctrl dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_stop     (stop),
        .i_duty_wr  (duty_wr),
        .i_duty_val (duty_val),
        .i_uif_in   (uif_in),
        .i_cc1if_in (cc1if_in),
        .o_tim_rst  (tim_rst),
        .o_ld_reg   (ld_reg),
        .o_ld_data  (ld_data),
        .o_uif_rst  (uif_rst),
        .o_cc1if_rst(cc1if_rst),
        .o_busy     (busy),
        .o_done     (done),
        .o_upd_cnt  (upd_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Logged cycle number = edges seen + 1, i.e. the cycle following edge cyc.
    always @(negedge clk) begin
        if (ld_reg != 4'hA) begin
            wq_reg.push_back(ld_reg);
            wq_data.push_back(ld_data);
            wq_cyc.push_back(cyc + 1);
        end
        if (uif_rst) uq.push_back(cyc + 1);
        if (cc1if_rst) cq.push_back(cyc + 1);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        wq_reg.delete();
        wq_data.delete();
        wq_cyc.delete();
        uq.delete();
        cq.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++; if (tim_rst !== 1'b1) begin bad++; $display("FAIL rst_tim_rst got %b want 1", tim_rst); end
        total++; if (ld_reg !== 4'hA) begin bad++; $display("FAIL rst_ld_reg got %h want a", ld_reg); end
        total++; if (ld_data !== 32'd0) begin bad++; $display("FAIL rst_ld_data got %h want 0", ld_data); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_busy_done got %b%b want 00", busy, done); end
        total++; if (uif_rst !== 1'b0 || cc1if_rst !== 1'b0) begin bad++; $display("FAIL rst_flags got %b%b want 00", uif_rst, cc1if_rst); end
        total++; if (upd_cnt !== 16'd0) begin bad++; $display("FAIL rst_upd_cnt got %0d want 0", upd_cnt); end
        rst_n = 1'b1;
        repeat (2) tick();
        total++; if (tim_rst !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL idle_after_rst got tim_rst=%b done=%b want 1 0", tim_rst, done); end
    endtask

    task automatic check_cfg_run(input string tag);
        int k;
        int c;
        clear_log();
        tick();
        start = 1'b1;
        k = cyc + 1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            c = cyc + 1;
            total++; if (tim_rst !== (c <= k + 2)) begin bad++; $display("FAIL %s_tim_rst cyc k+%0d got %b want %b", tag, c - k, tim_rst, (c <= k + 2)); end
            total++; if (busy !== (c >= k + 1 && c <= k + 12)) begin bad++; $display("FAIL %s_busy cyc k+%0d got %b want %b", tag, c - k, busy, (c >= k + 1 && c <= k + 12)); end
            total++; if (done !== (c >= k + 13)) begin bad++; $display("FAIL %s_done cyc k+%0d got %b want %b", tag, c - k, done, (c >= k + 13)); end
            if (i < 14) tick();
        end
        total++;
        if (wq_reg.size() != 10) begin
            bad++; $display("FAIL %s_write_count got %0d want 10", tag, wq_reg.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                total++;
                if (wq_reg[i] !== 4'(cfg_r[i]) || wq_data[i] !== 32'(cfg_d[i]) || wq_cyc[i] != k + 3 + i) begin
                    bad++;
                    $display("FAIL %s_write%0d got (%0d,%0h)@k+%0d want (%0d,%0h)@k+%0d", tag, i,
                             wq_reg[i], wq_data[i], wq_cyc[i] - k, cfg_r[i], cfg_d[i], 3 + i);
                end
            end
        end
    endtask

    task automatic test_duty();
        logic [31:0] v;
        logic [31:0] want;
        int j;
        logic b2b;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: v = 32'd5000;
                1: v = 32'd20000;
                2: v = 32'd9999;
                3: v = 32'd10000;
                4: v = 32'd0;
                5: v = 32'hFFFF_FFFF;
                6: v = 32'($urandom_range(0, 9999));
                default: v = $urandom();
            endcase
            want = (v > 32'd9999) ? 32'd9999 : v;
            b2b = (i % 2) == 1;
            clear_log();
            tick();
            duty_wr = 1'b1;
            duty_val = v;
            j = cyc + 1;
            tick();
            duty_wr = b2b;
            duty_val = $urandom();
            total++; if (ld_reg !== 4'd9 || ld_data !== want) begin bad++; $display("FAIL duty%0d_write got (%0d,%0d) want (9,%0d)", i, ld_reg, ld_data, want); end
            total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL duty%0d_upd_flags got done=%b busy=%b want 0 1", i, done, busy); end
            tick();
            duty_wr = 1'b0;
            total++; if (done !== 1'b1 || ld_reg !== 4'hA) begin bad++; $display("FAIL duty%0d_back_run got done=%b ld_reg=%h want 1 a", i, done, ld_reg); end
            repeat (2) tick();
            total++; if (wq_reg.size() != 1 || wq_cyc[0] != j + 1) begin bad++; $display("FAIL duty%0d_single_write got %0d writes want 1 at j+1", i, wq_reg.size()); end
        end
    endtask

    task automatic test_stop_duty();
        int j;
        clear_log();
        tick();
        stop = 1'b1;
        duty_wr = 1'b1;
        duty_val = 32'(($urandom_range(0, 9999)));
        j = cyc + 1;
        tick();
        stop = 1'b0;
        duty_wr = 1'b0;
        total++; if (ld_reg !== 4'd0 || ld_data !== 32'hA0) begin bad++; $display("FAIL stopduty_cr1 got (%0d,%h) want (0,a0)", ld_reg, ld_data); end
        total++; if (done !== 1'b0 || busy !== 1'b1 || tim_rst !== 1'b0) begin bad++; $display("FAIL stopduty_stop_flags got done=%b busy=%b tim_rst=%b want 0 1 0", done, busy, tim_rst); end
        tick();
        total++; if (tim_rst !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL stopduty_idle got tim_rst=%b done=%b busy=%b want 1 0 0", tim_rst, done, busy); end
        repeat (2) tick();
        total++; if (wq_reg.size() != 1 || wq_reg[0] !== 4'd0 || wq_cyc[0] != j + 1) begin bad++; $display("FAIL stopduty_writes got %0d writes want 1 CR1 write", wq_reg.size()); end
    endtask

    task automatic test_stop_cfg();
        bit found;
        bit saw_done;
        clear_log();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            if (ld_reg === 4'd6) found = 1'b1;
            else tick();
        end
        total++; if (!found) begin bad++; $display("FAIL stopcfg_reach_step3 got timeout want ARR write"); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        total++; if (ld_reg !== 4'hA || tim_rst !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL stopcfg_abort got ld_reg=%h tim_rst=%b busy=%b want a 1 0", ld_reg, tim_rst, busy); end
        saw_done = 1'b0;
        for (int n = 0; n < 15; n++) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        total++; if (saw_done) begin bad++; $display("FAIL stopcfg_done got 1 want 0"); end
        total++;
        if (wq_reg.size() != 4) begin
            bad++; $display("FAIL stopcfg_write_count got %0d want 4", wq_reg.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (wq_reg[i] !== 4'(cfg_r[i]) || wq_data[i] !== 32'(cfg_d[i])) begin
                    bad++; $display("FAIL stopcfg_write%0d got (%0d,%0h) want (%0d,%0h)", i, wq_reg[i], wq_data[i], cfg_r[i], cfg_d[i]);
                end
            end
        end
    endtask

    task automatic test_flags();
        int up_exp[$];
        int cc_exp[$];
        logic pu;
        logic pc;
        logic u;
        logic c;
        int e;
        logic [9:0] plan_u;
        logic [9:0] plan_c;
        plan_u = 10'b0011100111;
        plan_c = 10'b0000000100;
        pu = uif_in;
        pc = cc1if_in;
        clear_log();
        for (int t = 0; t < 50; t++) begin
            tick();
            if (t < 10) begin
                u = plan_u[t];
                c = plan_c[t];
            end else if (t < 46) begin
                u = 1'($urandom_range(0, 1));
                c = 1'($urandom_range(0, 1));
            end else begin
                u = 1'b0;
                c = 1'b0;
            end
            uif_in = u;
            cc1if_in = c;
            e = cyc + 1;
            if (u && !pu) begin up_exp.push_back(e + 1); exp_upd = exp_upd + 16'd1; end
            if (c && !pc) cc_exp.push_back(e + 1);
            pu = u;
            pc = c;
            if (t == 11) begin
                total++; if (uq.size() != 2 || cq.size() != 1) begin bad++; $display("FAIL flags_plan_pulses got uif=%0d cc=%0d want 2 1", uq.size(), cq.size()); end
                total++; if (upd_cnt !== 16'd2) begin bad++; $display("FAIL flags_plan_upd_cnt got %0d want 2", upd_cnt); end
            end
        end
        repeat (3) tick();
        total++;
        if (uq.size() != up_exp.size()) begin
            bad++; $display("FAIL flags_uif_count got %0d want %0d", uq.size(), up_exp.size());
        end else begin
            for (int i = 0; i < uq.size(); i++) begin
                total++; if (uq[i] != up_exp[i]) begin bad++; $display("FAIL flags_uif%0d_cycle got %0d want %0d", i, uq[i], up_exp[i]); end
            end
        end
        total++;
        if (cq.size() != cc_exp.size()) begin
            bad++; $display("FAIL flags_cc_count got %0d want %0d", cq.size(), cc_exp.size());
        end else begin
            for (int i = 0; i < cq.size(); i++) begin
                total++; if (cq[i] != cc_exp[i]) begin bad++; $display("FAIL flags_cc%0d_cycle got %0d want %0d", i, cq[i], cc_exp[i]); end
            end
        end
        total++; if (upd_cnt !== exp_upd) begin bad++; $display("FAIL flags_upd_cnt got %0d want %0d", upd_cnt, exp_upd); end
    endtask

    task test_wrap();
        tick();
        force dut.r_upd_cnt = 16'hFFFF;
        tick();
        release dut.r_upd_cnt;
        exp_upd = 16'hFFFF;
        tick();
        total++; if (upd_cnt !== exp_upd) begin bad++; $display("FAIL wrap_preload got %h want %h", upd_cnt, exp_upd); end
        for (int p = 0; p < 2; p++) begin
            uif_in = 1'b1;
            tick();
            uif_in = 1'b0;
            tick();
            exp_upd = exp_upd + 16'd1;
            total++; if (upd_cnt !== exp_upd) begin bad++; $display("FAIL wrap_step%0d got %h want %h", p, upd_cnt, exp_upd); end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL midrst_start_ignored got done=%b want 1", done); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            if (ld_reg === 4'd7) found = 1'b1;
            else tick();
        end
        total++; if (!found) begin bad++; $display("FAIL midrst_reach_step6 got timeout want CCMR1 write"); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (tim_rst !== 1'b1 || ld_reg !== 4'hA || ld_data !== 32'd0) begin bad++; $display("FAIL midrst_async got tim_rst=%b ld_reg=%h ld_data=%h want 1 a 0", tim_rst, ld_reg, ld_data); end
        total++; if (busy !== 1'b0 || done !== 1'b0 || upd_cnt !== 16'd0) begin bad++; $display("FAIL midrst_async2 got busy=%b done=%b upd_cnt=%0d want 0 0 0", busy, done, upd_cnt); end
        exp_upd = 16'd0;
        repeat (2) tick();
        rst_n = 1'b1;
        check_cfg_run("replay");
    endtask

    initial begin
        test_reset();
        check_cfg_run("cfg");
        test_duty();
        test_stop_duty();
        test_stop_cfg();
        check_cfg_run("cfg2");
        test_flags();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
